// File: rtl/gemm_systolic_ctrl.sv
// rtl/gemm_systolic_ctrl.sv - feed/flush/writeback sequencer for the 4x4 output-stationary GEMM array
// Optional perf counters: define GEMM_CTRL_PERF_EN.
module gemm_systolic_ctrl #(
  parameter int NumRows   = 4,
  parameter int NumCols   = 4,
  parameter int AddrWidth = 10,
  parameter int KWidth    = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 start_i,
  input  logic [KWidth-1:0]    k_size_i,
  input  logic                 drain_east_i,
  input  logic [AddrWidth-1:0] base_a_i,
  input  logic [AddrWidth-1:0] base_b_i,
  input  logic [AddrWidth-1:0] base_c_i,
  output logic                 sram_rd_req_o,
  output logic [AddrWidth-1:0] sram_a_addr_o,
  output logic [AddrWidth-1:0] sram_b_addr_o,
  output logic                 valid_data_o,
  output logic                 zero_feed_o,
  output logic [1:0]           acc_mux_sel_o,
  output logic                 sram_c_we_o,
  output logic [AddrWidth-1:0] sram_c_addr_o,
  output logic                 busy_o,
  output logic                 done_o
`ifdef GEMM_CTRL_PERF_EN
  ,
  output logic [31:0]          perf_cycles_o,
  output logic [15:0]          perf_jobs_o
`endif
);

  localparam int FlushLen = NumRows + NumCols - 1;
  localparam int FlushW   = $clog2(NumRows + NumCols + 1);
  localparam int CntWidth = (KWidth > FlushW) ? KWidth : FlushW;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FEED,
    S_FLUSH,
    S_WB,
    S_DONE
  } state_t;

  state_t                state_q, state_d;
  logic [CntWidth-1:0]   cnt_q;
  logic [CntWidth-1:0]   cnt_last;
  logic [KWidth-1:0]     k_q;
  logic                  east_q;
  logic [AddrWidth-1:0]  base_a_q, base_b_q, base_c_q;
  logic                  rd_q;
  logic                  accept;
  logic                  valid_int;

  assign accept = (state_q == S_IDLE) && start_i;

  // Terminal count of the phase-local counter for the current state
  always_comb begin
    cnt_last = '0;
    case (state_q)
      S_FEED:  cnt_last = CntWidth'(k_q) - CntWidth'(1);
      S_FLUSH: cnt_last = CntWidth'(FlushLen - 1);
      S_WB:    cnt_last = east_q ? CntWidth'(NumCols - 1) : CntWidth'(NumRows - 1);
      default: cnt_last = '0;
    endcase
  end

  always_comb begin
    state_d       = state_q;
    sram_rd_req_o = 1'b0;
    sram_a_addr_o = '0;
    sram_b_addr_o = '0;
    acc_mux_sel_o = 2'b00;
    sram_c_we_o   = 1'b0;
    sram_c_addr_o = '0;
    done_o        = 1'b0;
    busy_o        = (state_q != S_IDLE);
    case (state_q)
      S_IDLE: begin
        if (start_i) state_d = (k_size_i == '0) ? S_DONE : S_FEED;
      end
      S_FEED: begin
        sram_rd_req_o = 1'b1;
        sram_a_addr_o = base_a_q + AddrWidth'(cnt_q);
        sram_b_addr_o = base_b_q + AddrWidth'(cnt_q);
        if (cnt_q == cnt_last) state_d = S_FLUSH;
      end
      S_FLUSH: begin
        if (cnt_q == cnt_last) state_d = S_WB;
      end
      S_WB: begin
        acc_mux_sel_o = east_q ? 2'b10 : 2'b01;
        sram_c_we_o   = 1'b1;
        sram_c_addr_o = base_c_q + AddrWidth'(cnt_q);
        if (cnt_q == cnt_last) state_d = S_DONE;
      end
      S_DONE: begin
        done_o  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    // The first FLUSH cycle still carries the last real operand through rd_q
    valid_int    = rd_q | (state_q == S_FLUSH);
    valid_data_o = valid_int;
    zero_feed_o  = valid_int & ~rd_q;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      k_q      <= '0;
      east_q   <= 1'b0;
      base_a_q <= '0;
      base_b_q <= '0;
      base_c_q <= '0;
      rd_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= (state_d != state_q) ? '0 : cnt_q + CntWidth'(1);
      rd_q    <= sram_rd_req_o;
      if (accept) begin
        k_q      <= k_size_i;
        east_q   <= drain_east_i;
        base_a_q <= base_a_i;
        base_b_q <= base_b_i;
        base_c_q <= base_c_i;
      end
    end
  end

`ifdef GEMM_CTRL_PERF_EN
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      perf_cycles_o <= '0;
      perf_jobs_o   <= '0;
    end else begin
      if (accept) perf_cycles_o <= '0;
      else if (busy_o) perf_cycles_o <= perf_cycles_o + 32'd1;
      if (done_o) perf_jobs_o <= perf_jobs_o + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_gemm_systolic_ctrl.sv
// tb/tb_gemm_systolic_ctrl.sv - directed table-driven bench for gemm_systolic_ctrl
module tb_gemm_systolic_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [7:0] k_size = '0;
  logic       east = 1'b0;
  logic [9:0] base_a = '0, base_b = '0, base_c = '0;
  logic       rd_req, valid_data, zero_feed, c_we, busy, done;
  logic [9:0] a_addr, b_addr, c_addr;
  logic [1:0] sel;
`ifdef GEMM_CTRL_PERF_EN
  logic [31:0] perf_cycles;
  logic [15:0] perf_jobs;
`endif

  int pass_cnt = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  gemm_systolic_ctrl dut (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start), .k_size_i(k_size),
    .drain_east_i(east), .base_a_i(base_a), .base_b_i(base_b), .base_c_i(base_c),
    .sram_rd_req_o(rd_req), .sram_a_addr_o(a_addr), .sram_b_addr_o(b_addr),
    .valid_data_o(valid_data), .zero_feed_o(zero_feed), .acc_mux_sel_o(sel),
    .sram_c_we_o(c_we), .sram_c_addr_o(c_addr), .busy_o(busy), .done_o(done)
`ifdef GEMM_CTRL_PERF_EN
    , .perf_cycles_o(perf_cycles), .perf_jobs_o(perf_jobs)
`endif
  );

  typedef struct packed {
    logic [7:0]  k;
    logic        east;
    logic [9:0]  ba, bb, bc;
    logic [63:0] rd, vd, zf, we, bs;
    logic [15:0] done_c;
    logic [1:0]  sel;
    logic [39:0] aseq, bseq, cseq;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    total_cnt++;
    if (got !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    else pass_cnt++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_job(input int idx, input vec_t v);
    logic [63:0] rd_m = '0, vd_m = '0, zf_m = '0, we_m = '0, bs_m = '0;
    logic [39:0] aseq = '0, bseq = '0, cseq = '0;
    logic [1:0]  sel_we = 2'b00, sel_other = 2'b00;
    int          n_rd = 0, n_we = 0, c = 1, done_c = -1;
    string       p;
    p = $sformatf("job%0d", idx);
    k_size = v.k; east = v.east; base_a = v.ba; base_b = v.bb; base_c = v.bc;
    start = 1'b1;
    tick();
    start = 1'b0;
    while (c < 600) begin
      if (c < 64) begin
        rd_m[c] = rd_req; vd_m[c] = valid_data; zf_m[c] = zero_feed;
        we_m[c] = c_we;   bs_m[c] = busy;
      end
      if (rd_req && n_rd < 4) begin
        aseq[39-10*n_rd -: 10] = a_addr;
        bseq[39-10*n_rd -: 10] = b_addr;
      end
      if (rd_req) n_rd++;
      if (c_we && n_we < 4) cseq[39-10*n_we -: 10] = c_addr;
      if (c_we) begin
        n_we++;
        sel_we = sel;
      end else begin
        sel_other = sel_other | sel;
      end
      if (done) begin
        done_c = c;
        break;
      end
      tick();
      c++;
    end
    chk({p, "_done_cycle"}, 64'(done_c), 64'(v.done_c));
    chk({p, "_rd_mask"}, rd_m, v.rd);
    chk({p, "_valid_mask"}, vd_m, v.vd);
    chk({p, "_zero_feed_mask"}, zf_m, v.zf);
    chk({p, "_we_mask"}, we_m, v.we);
    chk({p, "_busy_mask"}, bs_m, v.bs);
    chk({p, "_sel_wb"}, 64'(sel_we), 64'(v.sel));
    chk({p, "_sel_outside_wb"}, 64'(sel_other), 64'd0);
    chk({p, "_a_addrs"}, 64'(aseq), 64'(v.aseq));
    chk({p, "_b_addrs"}, 64'(bseq), 64'(v.bseq));
    chk({p, "_c_addrs"}, 64'(cseq), 64'(v.cseq));
    tick();
  endtask

  initial begin
    int first_done, second_done, n_done;
    // K=4 south, the headline scenario
    vecs[0] = '{8'd4, 1'b0, 10'h010, 10'h020, 10'h030,
                64'h1E, 64'hFFC, 64'hFC0, 64'hF000, 64'h1FFFE, 16'd16, 2'b01,
                {10'h010, 10'h011, 10'h012, 10'h013}, {10'h020, 10'h021, 10'h022, 10'h023},
                {10'h030, 10'h031, 10'h032, 10'h033}};
    // K=4 east drain
    vecs[1] = '{8'd4, 1'b1, 10'h100, 10'h200, 10'h300,
                64'h1E, 64'hFFC, 64'hFC0, 64'hF000, 64'h1FFFE, 16'd16, 2'b10,
                {10'h100, 10'h101, 10'h102, 10'h103}, {10'h200, 10'h201, 10'h202, 10'h203},
                {10'h300, 10'h301, 10'h302, 10'h303}};
    // K=0 goes straight to DONE
    vecs[2] = '{8'd0, 1'b0, 10'h010, 10'h020, 10'h030,
                64'h0, 64'h0, 64'h0, 64'h0, 64'h2, 16'd1, 2'b00, 40'h0, 40'h0, 40'h0};
    // A address wrap
    vecs[3] = '{8'd4, 1'b0, 10'h3FE, 10'h005, 10'h040,
                64'h1E, 64'hFFC, 64'hFC0, 64'hF000, 64'h1FFFE, 16'd16, 2'b01,
                {10'h3FE, 10'h3FF, 10'h000, 10'h001}, {10'h005, 10'h006, 10'h007, 10'h008},
                {10'h040, 10'h041, 10'h042, 10'h043}};
    // K=1 east with C address wrap
    vecs[4] = '{8'd1, 1'b1, 10'h07F, 10'h0AA, 10'h3FE,
                64'h2, 64'h1FC, 64'h1F8, 64'h1E00, 64'h3FFE, 16'd13, 2'b10,
                {10'h07F, 30'h0}, {10'h0AA, 30'h0},
                {10'h3FE, 10'h3FF, 10'h000, 10'h001}};
    // K=255, maximum reduction length
    vecs[5] = '{8'd255, 1'b0, 10'h000, 10'h010, 10'h020,
                64'hFFFF_FFFF_FFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFFC, 64'h0, 64'h0,
                64'hFFFF_FFFF_FFFF_FFFE, 16'd267, 2'b01,
                {10'h000, 10'h001, 10'h002, 10'h003}, {10'h010, 10'h011, 10'h012, 10'h013},
                {10'h020, 10'h021, 10'h022, 10'h023}};

    rst_n = 1'b0;
    tick();
    tick();
    chk("reset_outputs",
        64'({rd_req, a_addr, b_addr, valid_data, zero_feed, sel, c_we, c_addr, busy, done}), 64'd0);
    rst_n = 1'b1;
    tick();

    run_job(0, vecs[0]);
`ifdef GEMM_CTRL_PERF_EN
    chk("perf_cycles", 64'(perf_cycles), 64'd16);
    chk("perf_jobs", 64'(perf_jobs), 64'd1);
`endif
    for (int i = 1; i < 6; i++) run_job(i, vecs[i]);

    // start held high: second job only from the IDLE cycle after DONE
    first_done = -1; second_done = -1; n_done = 0;
    k_size = 8'd1; east = 1'b0; base_a = 10'h0; base_b = 10'h0; base_c = 10'h0;
    start = 1'b1;
    tick();
    for (int c = 1; c <= 27; c++) begin
      if (c == 14) chk("hold_idle_gap_busy", 64'(busy), 64'd0);
      if (c == 15) chk("hold_second_job_busy", 64'(busy), 64'd1);
      if (done) begin
        n_done++;
        if (first_done < 0) first_done = c;
        else second_done = c;
      end
      if (c == 27) start = 1'b0;
      tick();
    end
    chk("hold_done_count", 64'(n_done), 64'd2);
    chk("hold_first_done", 64'(first_done), 64'd13);
    chk("hold_second_done", 64'(second_done), 64'd27);
    for (int c = 0; c < 4; c++) tick();

    // reset mid-FLUSH aborts the job
    k_size = 8'd4; east = 1'b0; base_a = 10'h010; base_b = 10'h020; base_c = 10'h030;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c < 7; c++) tick();
    chk("flush_before_reset", 64'({valid_data, zero_feed, busy}), 64'b111);
    rst_n = 1'b0;
    tick();
    chk("abort_outputs",
        64'({rd_req, a_addr, b_addr, valid_data, zero_feed, sel, c_we, c_addr, busy, done}), 64'd0);
    rst_n = 1'b1;
    n_done = 0;
    for (int c = 0; c < 30; c++) begin
      if (done || busy || c_we || rd_req) n_done++;
      tick();
    end
    chk("abort_no_activity", 64'(n_done), 64'd0);
    run_job(6, vecs[0]);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/gemm_systolic_ctrl.md
Name: gemm_systolic_ctrl

Overview:
Sequencer for the 4x4 output-stationary GEMM systolic array. On a start command it does four things in order:
- streams K columns of A and K rows of B from SRAM into the array edges;
- flushes the skew pipeline with zero operands;
- drains the accumulators south or east while writing C rows or columns back to SRAM;
- pulses done.
It sits between the host/config interface and the array top, driving the array's valid_data, acc_mux_sel and SRAM address/strobe signals.

Parameters:
NumRows, 4, array rows (M)
NumCols, 4, array columns (N)
AddrWidth, 10, SRAM word-address width for A, B and C
KWidth, 8, width of the K (reduction length) field

Ports:
clk_i  in  1  clock
rst_ni  in  1  synchronous active-low reset
start_i  in  1  start request, sampled only in IDLE
k_size_i  in  KWidth  reduction length K, latched on accepted start
drain_east_i  in  1  0: drain south (acc_mux_sel 01), 1: drain east (10); latched on start
base_a_i  in  AddrWidth  A base word address, latched on start
base_b_i  in  AddrWidth  B base word address, latched on start
base_c_i  in  AddrWidth  C base word address, latched on start
sram_rd_req_o  out  1  A and B read strobe (SRAM read latency is 1 cycle)
sram_a_addr_o  out  AddrWidth  A read address
sram_b_addr_o  out  AddrWidth  B read address
valid_data_o  out  1  operand-valid to array
zero_feed_o  out  1  forces array edge operands to 0 (external mux)
acc_mux_sel_o  out  2  00 MAC, 01 drain south, 10 drain east; 11 is never driven
sram_c_we_o  out  1  C write strobe
sram_c_addr_o  out  AddrWidth  C write address
busy_o  out  1  high whenever state != IDLE
done_o  out  1  one-cycle completion pulse

Behaviour:
- Reset:
  - When rst_ni is low at a clock edge, state goes to IDLE and all outputs and counters go to 0.
  - Reset asserted mid-operation aborts the job immediately: no further SRAM strobes, no done_o.
- States: IDLE, FEED, FLUSH, WB, DONE. Let F = NumRows+NumCols-1 and D = NumRows if draining south, NumCols if draining east.
- IDLE:
  - start_i=1 with k_size_i!=0 latches the configuration and goes to FEED.
  - start_i=1 with k_size_i==0 goes straight to DONE with no SRAM access.
  - start_i is ignored in every other state.
- FEED (K cycles, k=0..K-1):
  - sram_rd_req_o=1, sram_a_addr_o=base_a+k, sram_b_addr_o=base_b+k, acc_mux_sel_o=00.
  - Goes to FLUSH after k=K-1.
- Registered read valid: rd_q = sram_rd_req_o delayed by one cycle.
  - valid_data_o = rd_q | (state==FLUSH).
  - zero_feed_o = valid_data_o & ~rd_q.
- FLUSH (F cycles):
  - sram_rd_req_o=0, acc_mux_sel_o=00.
  - The first FLUSH cycle carries the last real operand (rd_q=1, zero_feed_o=0).
  - Goes to WB after F cycles.
- WB (D cycles, i=0..D-1):
  - acc_mux_sel_o=01 or 10 per the latched drain_east_i.
  - sram_c_we_o=1, sram_c_addr_o=base_c+i, valid_data_o=0.
  - Goes to DONE after D cycles.
- DONE (1 cycle): done_o=1, acc_mux_sel_o=00, then IDLE.
  - A start_i in this cycle is ignored; a start_i in the following IDLE cycle is accepted.
- Address arithmetic is modulo 2^AddrWidth: base+offset wraps silently.
- K counts up to 2^KWidth-1 with no overflow into the next state.
- Latency: start accepted at edge t0 gives FEED cycles t0+1..t0+K and done_o in cycle t0+1+K+F+D. For K=0, done_o is in cycle t0+1.
- Signals not explicitly driven in a state are 0; acc_mux_sel_o defaults to 00.

Optional Feature:
GEMM_CTRL_PERF_EN:
- Defined: adds output perf_cycles_o (32 bits) and output perf_jobs_o (16 bits).
  - perf_cycles_o counts cycles with busy_o=1 in the current job. It is cleared on accepted start and holds its value after done.
  - perf_jobs_o increments on each done_o pulse and wraps at 2^16.
  - Both counters are cleared by reset.
- Undefined: neither port nor counter exists, and all other behaviour is identical.

Test Plan:
1. Reset then K=4, south drain, bases A=0x10, B=0x20, C=0x30, start at cycle 0 -> rd_req cycles 1-4 with A addresses 0x10-0x13 and B addresses 0x20-0x23; valid cycles 2-11 with zero_feed in cycles 6-11; we cycles 12-15 with C addresses 0x30-0x33 and acc_mux_sel=01; done in cycle 16.
2. K=4, drain_east=1 -> acc_mux_sel=10 during WB, 4 writes, done in cycle 16.
3. K=0 start -> no rd_req, no we, done in cycle 1, busy for 1 cycle.
4. base_a=0x3FE, K=4 -> A addresses 0x3FE, 0x3FF, 0x000, 0x001.
5. start held high throughout -> second job accepted only in the cycle after done's cycle; start pulses during busy have no effect.
6. rst_ni low in FLUSH -> next cycle all outputs 0 and state IDLE, no done; a subsequent start runs normally. With GEMM_CTRL_PERF_EN defined, scenario 1 gives perf_cycles_o=16 and perf_jobs_o=1.
